dig_formatter: RTL and testbench



---
 rtl/dig_formatter_pkg.sv | 19 +
 rtl/dig_formatter_bin2bcd_step.sv | 29 ++
 rtl/dig_formatter.sv | 114 +++++++++++
 tb/tb_dig_formatter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dig_formatter_pkg.sv
// rtl/dig_formatter_pkg.sv - shared constants and FSM encoding for dig_formatter
//
// Purpose : digit code constants, reset value of the 40-bit digit bus,
//           BCD accumulator width and the formatter FSM state type.
// Ports   : none (package).
package dig_formatter_pkg;

  localparam logic [4:0]  CODE_BLANK = 5'h10;
  localparam logic [4:0]  CODE_DASH  = 5'h11;
  localparam logic [39:0] DIG_RESET  = 40'h8421084210;
  localparam int          BCD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FMT   = 2'd2
  } state_t;

endpackage

// File: rtl/dig_formatter_bin2bcd_step.sv
// rtl/dig_formatter_bin2bcd_step.sv - one double-dabble step on a 4-nibble BCD accumulator
//
// Purpose : combinational add-3-then-shift of a 4-digit BCD accumulator.
// Ports   : bcd_in  [15:0] accumulator before the step
//           bit_in          next binary input bit (MSB first)
//           bcd_out [15:0]  accumulator after the step
module bin2bcd_step
  import dig_formatter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             bit_in,
  output logic [BCD_W-1:0] bcd_out
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < 4; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
    // A carry out of the top nibble only happens for values above 9999,
    // which are displayed as dashes anyway, so it is dropped.
    bcd_out = {adj[BCD_W-2:0], bit_in};
  end

endmodule

// File: rtl/dig_formatter.sv
// rtl/dig_formatter.sv - binary amounts to 8-digit seven-segment code bus
//
// Purpose : converts two binary amounts to BCD (one bit per clock) and
//           formats them into eight 5-bit digit codes: paid amount on
//           digits 7..4, change on digits 3..0. dig is only updated on
//           the cycle valid pulses, so the display never sees partials.
// Macro   : DIG_ZERO_BLANK_EN - when defined, leading zeros of each field
//           are shown as BLANK (units digit always shown).
// Ports   : clk, rst (async, active-high)
//           load        start request, sampled only in IDLE
//           val_a/val_b left (paid) / right (change) binary values
//           busy        high while a conversion runs
//           valid       one-cycle pulse when dig updates
//           dig [39:0]  digit 7 = dig[39:35] ... digit 0 = dig[4:0]
module dig_formatter
  import dig_formatter_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [IN_W-1:0] val_a,
  input  logic [IN_W-1:0] val_b,
  output logic            busy,
  output logic            valid,
  output logic [39:0]     dig
);

  localparam int              CNT_W    = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0]  MAX_IN   = IN_W'(MAX_VAL);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  sh_a, sh_b;
  logic [BCD_W-1:0] bcd_a, bcd_b, step_a, step_b;
  logic             ovf_a, ovf_b;

  bin2bcd_step u_step_a (.bcd_in(bcd_a), .bit_in(sh_a[IN_W-1]), .bcd_out(step_a));
  bin2bcd_step u_step_b (.bcd_in(bcd_b), .bit_in(sh_b[IN_W-1]), .bcd_out(step_b));

  function automatic logic [19:0] fmt_field(input logic [BCD_W-1:0] bcd, input logic ovf);
    logic [3:0][4:0] f;
    for (int i = 0; i < 4; i++) begin
      f[i] = {1'b0, bcd[4*i +: 4]};
    end
`ifdef DIG_ZERO_BLANK_EN
    if (bcd[15:12] == 4'd0) f[3] = CODE_BLANK;
    if (bcd[15:8]  == 8'd0) f[2] = CODE_BLANK;
    if (bcd[15:4]  == 12'd0) f[1] = CODE_BLANK;
`endif
    if (ovf) begin
      f = {4{CODE_DASH}};
    end
    return f;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (load) state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_LAST) state_next = ST_FMT;
      ST_FMT:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      dig   <= DIG_RESET;
      cnt   <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
      bcd_a <= '0;
      bcd_b <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      valid <= (state == ST_FMT);
      case (state)
        ST_IDLE: begin
          if (load) begin
            sh_a  <= val_a;
            sh_b  <= val_b;
            ovf_a <= (val_a > MAX_IN);
            ovf_b <= (val_b > MAX_IN);
            bcd_a <= '0;
            bcd_b <= '0;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_a <= step_a;
          bcd_b <= step_b;
          sh_a  <= {sh_a[IN_W-2:0], 1'b0};
          sh_b  <= {sh_b[IN_W-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
        end
        ST_FMT: begin
          dig <= {fmt_field(bcd_a, ovf_a), fmt_field(bcd_b, ovf_b)};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dig_formatter.sv
// tb/tb_dig_formatter.sv - self-checking bench for dig_formatter
module tb_dig_formatter;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic [IN_W-1:0] val_a = '0;
  logic [IN_W-1:0] val_b = '0;
  logic            busy;
  logic            valid;
  logic [39:0]     dig;

  int errors = 0;
  int checks = 0;

  dig_formatter #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .load(load), .val_a(val_a), .val_b(val_b),
    .busy(busy), .valid(valid), .dig(dig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by plain division, then display rules.
  function automatic logic [19:0] model_field(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (v > 9999) r[5*i +: 5] = 5'h11;
`ifdef DIG_ZERO_BLANK_EN
      else if (i > 0 && v < p) r[5*i +: 5] = 5'h10;
`endif
      else r[5*i +: 5] = 5'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [39:0] model_dig(input int a, input int b);
    return {model_field(a), model_field(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: presents load for exactly one rising edge.
  task automatic start(input int a, input int b);
    val_a = IN_W'(a);
    val_b = IN_W'(b);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check("busy_after_load", 40'(busy), 40'd1);
  endtask

  // Waits for valid; checks latency, busy, dig stability and final digits.
  // Optionally presents a rejected load at cycle inj.
  task automatic wait_valid(input string tag, input logic [39:0] exp,
                            input int inj, input int ia, input int ib);
    logic [39:0] prev;
    int n;
    prev = dig;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inj) begin
        val_a = IN_W'(ia);
        val_b = IN_W'(ib);
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
      if (valid) begin
        n = k;
        break;
      end
      check({tag, "_busy"}, 40'(busy), 40'd1);
      check({tag, "_stable"}, dig, prev);
    end
    check({tag, "_latency"}, 40'(n), 40'd15);
    check({tag, "_busy_end"}, 40'(busy), 40'd0);
    check({tag, "_dig"}, dig, exp);
  endtask

  initial begin
    int a, b;
    logic [39:0] held;

    repeat (2) @(negedge clk);
    check("reset_dig", dig, 40'h8421084210);
    check("reset_busy", 40'(busy), 40'd0);
    check("reset_valid", 40'(valid), 40'd0);
    rst = 1'b0;
    tick();

    // Basic conversion
    start(1234, 56);
    wait_valid("basic", model_dig(1234, 56), 0, 0, 0);
    tick();
    check("valid_one_cycle", 40'(valid), 40'd0);

    // Boundaries
    start(9999, 0);
    wait_valid("max_zero", model_dig(9999, 0), 0, 0, 0);
    start(10000, 321);
    wait_valid("ovf_a", model_dig(10000, 321), 0, 0, 0);
    start(7, 16383);
    wait_valid("ovf_b", model_dig(7, 16383), 0, 0, 0);

    // Reset mid-SHIFT aborts immediately
    start(4321, 8765);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("arst_dig", dig, 40'h8421084210);
    check("arst_busy", 40'(busy), 40'd0);
    check("arst_valid", 40'(valid), 40'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_idle_busy", 40'(busy), 40'd0);
    start(42, 908);
    wait_valid("post_rst", model_dig(42, 908), 0, 0, 0);

    // Load while busy is ignored; exactly one valid
    start(2468, 1357);
    wait_valid("reject", model_dig(2468, 1357), 5, 1111, 2222);
    held = dig;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("reject_no_valid", 40'(valid), 40'd0);
      check("reject_hold", dig, held);
    end

    // Back-to-back: load in the valid cycle
    start(5, 60);
    wait_valid("b2b_first", model_dig(5, 60), 0, 0, 0);
    start(900, 9);
    wait_valid("b2b_second", model_dig(900, 9), 0, 0, 0);

    // Random conversions
    for (int r = 0; r < 10; r++) begin
      a = (r % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      b = int'($urandom_range(0, 10500));
      start(a, b);
      wait_valid("random", model_dig(a, b), 0, 0, 0);
      repeat (int'($urandom_range(0, 3))) begin
        held = dig;
        tick();
        check("random_idle_hold", dig, held);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
